// File: rtl/nonce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nonce_pkg
// Description : Shared types and helpers for the multi-lane nonce generator.
// Revision    : 1.0 - initial release
// ============================================================================
package nonce_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NONCE_W   = 32;
  localparam int DEF_NUM_LANES = 4;

  // LSB position of a lane's slice in a flattened lane bus
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_lane.sv
`default_nettype none
// ============================================================================
// Module      : nonce_lane
// Description : One hash-core lane: holds the next nonce, flags validity
//               against the range top and strides by STEP on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_lane
  import nonce_pkg::*;
#(
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int STEP    = DEF_NUM_LANES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NONCE_W:0]   load_val,
  input  logic [NONCE_W-1:0] range_hi,
  input  logic               run,
  input  logic               clear,
  input  logic               ready,
  output logic               valid,
  output logic               fire,
  output logic               live_next,
  output logic [NONCE_W-1:0] nonce
);

  localparam logic [NONCE_W:0] STEP_W = (NONCE_W+1)'(STEP);

  logic [NONCE_W:0] next_q;
  logic [NONCE_W:0] next_d;
  logic [NONCE_W:0] top_w;

  // The extra MSB lets the stride run past the range top instead of wrapping
  assign top_w = {1'b0, range_hi};
  assign nonce = next_q[NONCE_W-1:0];

  // Validity, handshake, next-value selection and look-ahead liveness
  always_comb begin
    valid  = run && (next_q <= top_w);
    fire   = valid && ready;
    next_d = next_q;
    if (clear) begin
      next_d = '0;
    end else if (load) begin
      next_d = load_val;
    end else if (fire) begin
      next_d = next_q + STEP_W;
    end
    live_next = (next_d <= top_w);
  end

  // Next-nonce register
  always_ff @(posedge clk) begin
    if (!reset) begin
      next_q <= '0;
    end else begin
      next_q <= next_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nonce_range_gen.sv
`default_nettype none
// ============================================================================
// Module      : nonce_range_gen
// Description : Sweeps an inclusive nonce range across NUM_LANES lanes,
//               lane i issuing lo+i, lo+i+NUM_LANES, ... with per-lane
//               valid/ready, abort, done and an issued-nonce counter.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_range_gen
  import nonce_pkg::*;
#(
  parameter int NONCE_W   = DEF_NONCE_W,
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NONCE_W-1:0]           range_lo,
  input  logic [NONCE_W-1:0]           range_hi,
  output logic [NUM_LANES-1:0]         nonce_valid,
  input  logic [NUM_LANES-1:0]         nonce_ready,
  output logic [NUM_LANES*NONCE_W-1:0] nonce_out,
  output logic                         busy,
  output logic                         done,
  output logic [NONCE_W:0]             issued_cnt
);

  state_t               state_q, state_d;
  logic [NONCE_W-1:0]   hi_q, hi_d;
  logic [NONCE_W:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_LANES-1:0] fire_w;
  logic [NUM_LANES-1:0] live_w;
  logic                 run_w;
  logic                 accept_w;

  assign run_w    = (state_q == ST_RUN);
  // start is only honoured outside a sweep, and abort always overrides it
  assign accept_w = start && !abort && (state_q != ST_RUN);

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [NONCE_W:0] LANE_OFS = (NONCE_W+1)'(i);
      nonce_lane #(
        .NONCE_W (NONCE_W),
        .STEP    (NUM_LANES)
      ) u_lane (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_w),
        .load_val  ({1'b0, range_lo} + LANE_OFS),
        .range_hi  (hi_q),
        .run       (run_w),
        .clear     (abort),
        .ready     (nonce_ready[i]),
        .valid     (nonce_valid[i]),
        .fire      (fire_w[i]),
        .live_next (live_w[i]),
        .nonce     (nonce_out[lane_lsb(i, NONCE_W) +: NONCE_W])
      );
    end
  endgenerate

  // Sweep control: next state uses lane look-ahead so done rises right after the last handshake
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          hi_d    = range_hi;
          state_d = (range_lo <= range_hi) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!(|live_w)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Issued counter: cleared by an accepted start, otherwise adds this cycle's handshakes
  always_comb begin
    cnt_d = cnt_q;
    if (accept_w) begin
      cnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_d = cnt_d + (NONCE_W+1)'(fire_w[i]);
      end
    end
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign issued_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_range_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_range_gen
// Description : Self-checking bench for nonce_range_gen: a 32-bit and an
//               8-bit instance, compared every cycle against a range model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_range_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  // instance 0 : NONCE_W=32
  logic        start_a, abort_a;
  logic [31:0] lo_a, hi_a;
  logic [3:0]  rdy_a, nv_a;
  logic [127:0] no_a;
  logic        busy_a, done_a;
  logic [32:0] cnt_a;
  // instance 1 : NONCE_W=8
  logic        start_b, abort_b;
  logic [7:0]  lo_b, hi_b;
  logic [3:0]  rdy_b, nv_b;
  logic [31:0] no_b;
  logic        busy_b, done_b;
  logic [8:0]  cnt_b;

  nonce_range_gen dut_a (
    .clk(clk), .reset(rstn), .start(start_a), .abort(abort_a),
    .range_lo(lo_a), .range_hi(hi_a), .nonce_valid(nv_a), .nonce_ready(rdy_a),
    .nonce_out(no_a), .busy(busy_a), .done(done_a), .issued_cnt(cnt_a)
  );

  nonce_range_gen #(.NONCE_W(8), .NUM_LANES(4)) dut_b (
    .clk(clk), .reset(rstn), .start(start_b), .abort(abort_b),
    .range_lo(lo_b), .range_hi(hi_b), .nonce_valid(nv_b), .nonce_ready(rdy_b),
    .nonce_out(no_b), .busy(busy_b), .done(done_b), .issued_cnt(cnt_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lane i of a sweep owns lo+i+4*k after k handshakes; it is live while that is <= hi.
  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
  mmode_t m_mode [2];
  longint m_lo [2];
  longint m_hi [2];
  longint m_cnt[2];
  int     m_k  [2][4];

  function automatic longint m_nonce(input int d, input int i);
    return m_lo[d] + i + 64'(m_k[d][i]) * 4;
  endfunction

  function automatic bit m_valid(input int d, input int i);
    return (m_mode[d] == M_RUN) && (m_nonce(d, i) <= m_hi[d]);
  endfunction

  task automatic m_step(input int d);
    bit s, a, any;
    logic [3:0] r;
    longint li, hv;
    s  = (d == 0) ? start_a : start_b;
    a  = (d == 0) ? abort_a : abort_b;
    r  = (d == 0) ? rdy_a   : rdy_b;
    li = (d == 0) ? 64'(lo_a) : 64'(lo_b);
    hv = (d == 0) ? 64'(hi_a) : 64'(hi_b);
    if (!rstn) begin
      m_mode[d] = M_IDLE; m_cnt[d] = 0; m_lo[d] = 0; m_hi[d] = 0;
      for (int i = 0; i < 4; i++) m_k[d][i] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_valid(d, i) && r[i]) begin
        m_k[d][i]++;
        m_cnt[d]++;
      end
    end
    if (a) begin
      m_mode[d] = M_IDLE;
    end else if (s && m_mode[d] != M_RUN) begin
      m_lo[d] = li; m_hi[d] = hv; m_cnt[d] = 0;
      for (int i = 0; i < 4; i++) m_k[d][i] = 0;
      m_mode[d] = (li <= hv) ? M_RUN : M_DONE;
    end else if (m_mode[d] == M_RUN) begin
      any = 1'b0;
      for (int i = 0; i < 4; i++) any |= m_valid(d, i);
      if (!any) m_mode[d] = M_DONE;
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) m_step(d);
  end

  // handshakes actually issued by each DUT lane, for literal sequence checks
  longint hs_q[2][4][$];

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] v, r;
    longint bz, dn, cn;
    longint nz[4];
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          v = nv_a; r = rdy_a; bz = 64'(busy_a); dn = 64'(done_a); cn = 64'(cnt_a);
          for (int i = 0; i < 4; i++) nz[i] = 64'(no_a[i*32 +: 32]);
        end else begin
          v = nv_b; r = rdy_b; bz = 64'(busy_b); dn = 64'(done_b); cn = 64'(cnt_b);
          for (int i = 0; i < 4; i++) nz[i] = 64'(no_b[i*8 +: 8]);
        end
        chk($sformatf("busy d%0d", d), bz, 64'(m_mode[d] == M_RUN));
        chk($sformatf("done d%0d", d), dn, 64'(m_mode[d] == M_DONE));
        chk($sformatf("cnt d%0d", d), cn, m_cnt[d]);
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("valid d%0d l%0d", d, i), 64'(v[i]), 64'(m_valid(d, i)));
          if (m_valid(d, i))
            chk($sformatf("nonce d%0d l%0d", d, i), nz[i], m_nonce(d, i));
          if (rstn && v[i] && r[i]) hs_q[d][i].push_back(nz[i]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_q();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) hs_q[d][i].delete();
  endtask

  task automatic do_start(input int d, input longint lo, input longint hi);
    if (d == 0) begin lo_a = 32'(lo); hi_a = 32'(hi); start_a = 1'b1; end
    else        begin lo_b = 8'(lo);  hi_b = 8'(hi);  start_b = 1'b1; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_lane(input int d, input int lane, input int n,
                            input longint e0, input longint e1, input longint e2);
    longint e[3];
    e = '{e0, e1, e2};
    chk($sformatf("seqlen d%0d l%0d", d, lane), 64'(hs_q[d][lane].size()), 64'(n));
    for (int j = 0; j < n && j < hs_q[d][lane].size(); j++)
      chk($sformatf("seq d%0d l%0d #%0d", d, lane, j), hs_q[d][lane][j], e[j]);
  endtask

  initial begin
    rstn = 1'b0;
    start_a = 0; abort_a = 0; lo_a = 0; hi_a = 0; rdy_a = 0;
    start_b = 0; abort_b = 0; lo_b = 0; hi_b = 0; rdy_b = 0;
    tick(); tick();
    chk_en = 1'b1;
    // reset state
    chk("rst busy", 64'(busy_a), 0);
    chk("rst done", 64'(done_a), 0);
    chk("rst cnt", 64'(cnt_a), 0);
    chk("rst valid", 64'(nv_a), 0);
    chk("rst nonce_out", 64'(no_a[63:0]) | 64'(no_a[127:64]), 0);
    rstn = 1'b1;
    tick();

    // full sweep 0..9, all ready
    clr_q(); rdy_a = 4'hF;
    do_start(0, 0, 9);
    chk("sweep busy t+1", 64'(busy_a), 1);
    tick(); tick();
    chk("sweep done early", 64'(done_a), 0);
    tick();
    chk("sweep done t+4", 64'(done_a), 1);
    chk("sweep cnt", 64'(cnt_a), 10);
    check_lane(0, 0, 3, 0, 4, 8);
    check_lane(0, 1, 3, 1, 5, 9);
    check_lane(0, 2, 2, 2, 6, 0);
    check_lane(0, 3, 2, 3, 7, 0);

    // backpressure on lane 1, range 100..107
    clr_q(); rdy_a = 4'b1101;
    do_start(0, 100, 107);
    tick(); tick(); tick();
    chk("bp lane1 valid", 64'(nv_a[1]), 1);
    chk("bp lane1 hold", 64'(no_a[63:32]), 101);
    tick(); tick();
    rdy_a = 4'hF;
    tick(); tick();
    chk("bp done", 64'(done_a), 1);
    chk("bp cnt", 64'(cnt_a), 8);
    check_lane(0, 0, 2, 100, 104, 0);
    check_lane(0, 1, 2, 101, 105, 0);

    // top of range on the 8-bit instance
    clr_q(); rdy_b = 4'hF;
    do_start(1, 250, 255);
    tick(); tick(); tick(); tick();
    chk("top done", 64'(done_b), 1);
    chk("top cnt", 64'(cnt_b), 6);
    check_lane(1, 0, 2, 250, 254, 0);
    check_lane(1, 1, 2, 251, 255, 0);
    check_lane(1, 2, 1, 252, 0, 0);
    check_lane(1, 3, 1, 253, 0, 0);

    // empty range from DONE, then single-nonce range
    clr_q();
    do_start(0, 20, 19);
    chk("empty done", 64'(done_a), 1);
    chk("empty valid", 64'(nv_a), 0);
    chk("empty cnt", 64'(cnt_a), 0);
    do_start(0, 7, 7);
    chk("single busy", 64'(busy_a), 1);
    tick(); tick();
    chk("single cnt", 64'(cnt_a), 1);
    check_lane(0, 0, 1, 7, 0, 0);
    check_lane(0, 1, 0, 0, 0, 0);

    // abort mid-sweep: three handshake edges, abort on the third
    clr_q();
    do_start(0, 0, 1000);
    tick(); tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort valid", 64'(nv_a), 0);
    chk("abort busy", 64'(busy_a), 0);
    chk("abort done", 64'(done_a), 0);
    chk("abort cnt", 64'(cnt_a), 12);
    start_a = 1'b1; abort_a = 1'b1; lo_a = 5; hi_a = 9;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    chk("start+abort busy", 64'(busy_a), 0);
    chk("start+abort cnt", 64'(cnt_a), 12);
    tick();

    // start during RUN is ignored, then reset mid-RUN, then fresh sweep
    do_start(0, 500, 2000);
    tick();
    do_start(0, 0, 3);
    chk("ignored start lane0", 64'(no_a[31:0]), 508);
    chk("ignored start busy", 64'(busy_a), 1);
    rstn = 1'b0;
    tick();
    chk("midrst busy", 64'(busy_a), 0);
    chk("midrst valid", 64'(nv_a), 0);
    chk("midrst cnt", 64'(cnt_a), 0);
    chk("midrst nonce_out", 64'(no_a[63:0]) | 64'(no_a[127:64]), 0);
    rstn = 1'b1;
    tick();
    clr_q();
    do_start(0, 30, 35);
    tick(); tick(); tick();
    chk("fresh done", 64'(done_a), 1);
    chk("fresh cnt", 64'(cnt_a), 6);
    check_lane(0, 0, 2, 30, 34, 0);
    check_lane(0, 3, 1, 33, 0, 0);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonce_range_gen.md
# nonce_range_gen

Parametrised multi-lane nonce generator for the mining datapath. Sweeps a programmable inclusive range [range_lo, range_hi] and deals nonces to NUM_LANES hash cores: lane i issues range_lo+i, range_lo+i+NUM_LANES, and so on. Each lane has a valid/ready handshake and stops cleanly at range end, without wrap-around. Supports abort, and a global done flag when the range is exhausted.

## Interface
- NONCE_W, 32, nonce width in bits (≥8)
- NUM_LANES, 4, number of hash-core lanes (1..16)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latch range and begin sweep (honoured only in IDLE or DONE)
- abort  in  1  one-cycle pulse; stop sweep, return to IDLE
- range_lo  in  NONCE_W  first nonce (inclusive), sampled on accepted start
- range_hi  in  NONCE_W  last nonce (inclusive), sampled on accepted start
- nonce_valid  out  NUM_LANES  per-lane nonce available
- nonce_ready  in  NUM_LANES  per-lane core accepts nonce
- nonce_out  out  NUM_LANES*NONCE_W  lane i at bits [i*NONCE_W +: NONCE_W]
- busy  out  1  high in RUN
- done  out  1  high in DONE; range fully issued
- issued_cnt  out  NONCE_W+1  nonces handed off since last accepted start

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: start && !abort && range_lo ≤ range_hi.
  - IDLE→DONE: start && !abort && range_lo > range_hi (empty range, no nonces issued).
  - RUN→DONE: all lanes exhausted.
  - RUN→IDLE: abort.
  - DONE→RUN/DONE: start, same rules as from IDLE.
  - DONE→IDLE: abort.
- start during RUN: ignored. abort and start in the same cycle: abort wins.
- Each lane keeps a NONCE_W+1-bit next value. On accepted start, lane i loads range_lo+i.
- Lane valid rule: a lane is valid in RUN while next ≤ {1'b0, range_hi}.
- Lanes with range_lo+i > range_hi are exhausted from the start. Example: NUM_LANES=4, range 10..11 → lanes 2 and 3 are never valid.
- Handshake (valid && ready) on lane i: next += NUM_LANES, computed in NONCE_W+1 bits. No wrap: at range_hi=2^NONCE_W−1, a lane that crosses the top exhausts and does not restart at 0.
- Handshake rules: while valid is high and ready is low, nonce_out and valid hold stable. ready while valid is low has no effect.
- issued_cnt = sum of per-cycle handshakes across all lanes. It cleared on accepted start and holds its value in DONE and IDLE. Maximum value is 2^NONCE_W, hence the extra bit.
- nonce_out of a lane that is not valid is don't-care. The bench must not check it.

## Timing
- Reset (reset=0 at an edge): state IDLE, nonce_valid=0, nonce_out=0, busy=0, done=0, issued_cnt=0. Reset mid-RUN takes effect at the next edge and discards the range.
- start accepted at edge t: busy and lane valids high from cycle t+1. done is high at t+1 for an empty range.
- Throughput: one nonce per lane per cycle when ready is held high. A handshake at edge t presents the next nonce from t+1.
- Last handshake in the sweep at edge t: valid low at t+1, busy=0 and done=1 at t+1, issued_cnt final at t+1.
- abort at edge t: all valids and busy low at t+1. done=0. issued_cnt holds its value. A handshake coinciding with abort still counts.
- done stays high until an accepted start or abort. A start from DONE clears done at t+1, unless the new range is empty.

## Structure
- Shared package nonce_pkg holds:
  - fsm state typedef (IDLE/RUN/DONE)
  - default NONCE_W and NUM_LANES constants
  - a lane-slice index helper
- Sub-module nonce_lane, generated NUM_LANES times. It contains:
  - the next register
  - the valid/exhausted logic
  - the handshake advance by NUM_LANES
  - inputs: load value, range_hi, run, clear
- Top level contains the FSM, the all-exhausted reduction, and the popcount-and-accumulate logic for issued_cnt.

## Test plan
- Reset then default params, range 0..9, all ready=1 → lanes issue {0,4,8},{1,5,9},{2,6},{3,7}; done at cycle 4 after start; issued_cnt=10.
- Backpressure on range 100..107: hold lane 1 ready=0 for 5 cycles → lane 1 holds 101 stable with valid high; other lanes continue; after release, lane 1 issues 101 then 105; issued_cnt=8.
- Top of range, NONCE_W=8, range 250..255, ready=1 → lane 0 issues 250 and 254, lane 1 issues 251 and 255; no nonce 0..3 ever appears; done; issued_cnt=6.
- Empty or short ranges: range 20..19 → done at t+1, no valid. Range 7..7 → only lane 0 issues 7; issued_cnt=1.
- Abort mid-sweep: range 0..1000, abort after 3 cycles with all ready → valids drop next cycle, done=0, issued_cnt=12. start and abort together → stays IDLE.
- Reset mid-RUN, and start during RUN (ignored) → all outputs at reset values. A fresh start afterwards sweeps the new range correctly.
